// File: rtl/debug_uart.sv
// debug_uart: 8N1 serial transceiver for the debug controller COM port.
// Fixed divisor of clk per bit; RX and TX run fully independently.
//
// Parameters:
//   CLK_DIV       clk cycles per bit (4..65535, >= 8 with majority RX)
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   uart_rxd      serial input (asynchronous, 2-flop synchronized)
//   uart_txd      serial output, idle high
//   rx_data       last received byte
//   read_ready    rx_data valid and not yet acknowledged
//   int_ack       consumer acknowledge, clears read_ready/rx_overrun
//   tx_data       byte to transmit
//   write_enable  transmit request
//   write_ready   transmitter idle
//   rx_overrun    sticky: byte dropped while read_ready was set
//   rx_frame_err  one-cycle pulse: stop bit sampled low
//
// Build option: define DEBUG_UART_RX_MAJORITY_EN for a 2-of-3 majority
// vote around every RX sample point (one cycle of extra RX latency).

module debug_uart #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       read_ready,
  input  logic       int_ack,
  input  logic [7:0] tx_data,
  input  logic       write_enable,
  output logic       write_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

`ifdef DEBUG_UART_RX_MAJORITY_EN
  // Sample one cycle late so the vote window is centred on mid-bit.
  localparam logic [15:0] RX_HALF = 16'(CLK_DIV / 2);
`else
  localparam logic [15:0] RX_HALF = 16'(CLK_DIV / 2 - 1);
`endif

  // ---------------- RX synchronizer ----------------

  logic rxd_s1;
  logic rxd_s2;
  logic rx_smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
    end
  end

`ifdef DEBUG_UART_RX_MAJORITY_EN
  logic rxd_h1;
  logic rxd_h2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_h1 <= 1'b1;
      rxd_h2 <= 1'b1;
    end else begin
      rxd_h1 <= rxd_s2;
      rxd_h2 <= rxd_h1;
    end
  end

  assign rx_smp = (rxd_h2 & rxd_h1) |
                  (rxd_h2 & rxd_s2) |
                  (rxd_h1 & rxd_s2);
`else
  assign rx_smp = rxd_s2;
`endif

  // ---------------- RX FSM ----------------

  state_t      rx_st;
  state_t      rx_st_n;
  logic [15:0] rx_cnt;
  logic [15:0] rx_cnt_n;
  logic [2:0]  rx_bit;
  logic [2:0]  rx_bit_n;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_sh_n;
  logic        rx_brk;
  logic        rx_brk_n;
  logic        rx_done;
  logic        rx_ferr_n;
  logic        rx_tick;

  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st  <= IDLE;
      rx_cnt <= 16'd0;
      rx_bit <= 3'd0;
      rx_sh  <= 8'd0;
      rx_brk <= 1'b0;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
      rx_brk <= rx_brk_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    rx_cnt_n  = rx_cnt;
    rx_bit_n  = rx_bit;
    rx_sh_n   = rx_sh;
    rx_brk_n  = rx_brk;
    rx_done   = 1'b0;
    rx_ferr_n = 1'b0;
    unique case (rx_st)
      IDLE: begin
        if (!rxd_s2) begin
          rx_st_n  = START;
          rx_cnt_n = RX_HALF;
        end
      end
      START: begin
        if (rx_tick) begin
          if (!rx_smp) begin
            rx_st_n  = DATA;
            rx_cnt_n = DIV_M1;
            rx_bit_n = 3'd0;
          end else begin
            // Glitch, not a start bit: drop silently.
            rx_st_n = IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      DATA: begin
        if (rx_tick) begin
          rx_sh_n  = {rx_smp, rx_sh[7:1]};
          rx_cnt_n = DIV_M1;
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) begin
            rx_st_n = STOP;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      STOP: begin
        if (rx_brk) begin
          // Hold off until the line is released so a
          // break cannot look like a new start bit.
          if (rxd_s2) begin
            rx_st_n  = IDLE;
            rx_brk_n = 1'b0;
          end
        end else if (rx_tick) begin
          if (rx_smp) begin
            rx_done = 1'b1;
            rx_st_n = IDLE;
          end else begin
            rx_ferr_n = 1'b1;
            rx_brk_n  = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: begin
        rx_st_n = IDLE;
      end
    endcase
  end

  // ---------------- RX consumer handshake ----------------

  logic rx_load;

  // An ack in the same cycle frees the slot for the new byte.
  assign rx_load = rx_done & (~read_ready | int_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= 8'd0;
      read_ready   <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= rx_ferr_n;
      if (rx_load) begin
        rx_data    <= rx_sh;
        read_ready <= 1'b1;
      end else if (int_ack) begin
        read_ready <= 1'b0;
      end
      if (int_ack) begin
        rx_overrun <= 1'b0;
      end else if (rx_done && read_ready) begin
        rx_overrun <= 1'b1;
      end
    end
  end

  // ---------------- TX FSM ----------------

  state_t      tx_st;
  state_t      tx_st_n;
  logic [15:0] tx_cnt;
  logic [15:0] tx_cnt_n;
  logic [2:0]  tx_bit;
  logic [2:0]  tx_bit_n;
  logic [7:0]  tx_sh;
  logic [7:0]  tx_sh_n;
  logic        txd_n;
  logic        wr_rdy_n;
  logic        tx_tick;

  assign tx_tick = (tx_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st       <= IDLE;
      tx_cnt      <= 16'd0;
      tx_bit      <= 3'd0;
      tx_sh       <= 8'd0;
      uart_txd    <= 1'b1;
      write_ready <= 1'b1;
    end else begin
      tx_st       <= tx_st_n;
      tx_cnt      <= tx_cnt_n;
      tx_bit      <= tx_bit_n;
      tx_sh       <= tx_sh_n;
      uart_txd    <= txd_n;
      write_ready <= wr_rdy_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    txd_n    = uart_txd;
    wr_rdy_n = write_ready;
    unique case (tx_st)
      IDLE: begin
        // Only the accept cycle matters; a held
        // write_enable is ignored once busy.
        if (write_enable && write_ready) begin
          tx_st_n  = START;
          tx_cnt_n = DIV_M1;
          tx_sh_n  = tx_data;
          txd_n    = 1'b0;
          wr_rdy_n = 1'b0;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_st_n  = DATA;
          tx_cnt_n = DIV_M1;
          tx_bit_n = 3'd0;
          txd_n    = tx_sh[0];
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      DATA: begin
        if (tx_tick) begin
          tx_cnt_n = DIV_M1;
          if (tx_bit == 3'd7) begin
            tx_st_n = STOP;
            txd_n   = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = {1'b0, tx_sh[7:1]};
            txd_n    = tx_sh[1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      STOP: begin
        if (tx_tick) begin
          tx_st_n  = IDLE;
          wr_rdy_n = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: begin
        tx_st_n  = IDLE;
        txd_n    = 1'b1;
        wr_rdy_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_uart.sv
// tb_debug_uart: directed + random checks of debug_uart at CLK_DIV=8.
// Expected values come from a frame-level model of the UART rules.

module tb_debug_uart;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic       uart_txd;
  logic [7:0] rx_data;
  logic       read_ready;
  logic       int_ack;
  logic [7:0] tx_data;
  logic       write_enable;
  logic       write_ready;
  logic       rx_overrun;
  logic       rx_frame_err;

  debug_uart #(.CLK_DIV(DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .uart_txd     (uart_txd),
    .rx_data      (rx_data),
    .read_ready   (read_ready),
    .int_ack      (int_ack),
    .tx_data      (tx_data),
    .write_enable (write_enable),
    .write_ready  (write_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the consumer-visible RX state.
  logic [7:0] m_data;
  logic       m_ready;
  logic       m_ovr;

  int ferr_cnt;
  int rdy_hi;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      if (rx_frame_err) ferr_cnt++;
      if (read_ready) rdy_hi++;
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      idle(DIV);
    end
    uart_rxd = 1'b1;
    idle(DIV);
    if (stop) begin
      if (!m_ready) begin
        m_data  = d;
        m_ready = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    tick();
  endtask

  task automatic check_rx(input string tag);
    check({tag, " read_ready"}, 32'(read_ready), 32'(m_ready));
    check({tag, " rx_data"}, 32'(rx_data), 32'(m_data));
    check({tag, " rx_overrun"}, 32'(rx_overrun), 32'(m_ovr));
  endtask

  // Holds write_enable for 2 cycles and checks the line waveform.
  task automatic send_tx(input logic [7:0] d, input string tag);
    logic       q[$];
    logic [9:0] f;
    int         lo;
    int         first;
    int         bad;
    int         tail;
    f     = {1'b1, d, 1'b0};
    lo    = 0;
    first = -1;
    bad   = 0;
    tail  = 0;
    tx_data      = d;
    write_enable = 1'b1;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (i == 1) write_enable = 1'b0;
      q.push_back(uart_txd);
      if (!write_ready) lo++;
      if (first < 0 && !uart_txd) first = i;
    end
    check({tag, " start latency"}, 32'(first), 32'd0);
    if (first < 0) first = 0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s bit%0d", tag, k),
            32'(q[first + k*DIV + DIV/2]), 32'(f[k]));
      for (int j = 0; j < DIV; j++)
        if (q[first + k*DIV + j] !== f[k]) bad++;
    end
    for (int i = first + 10*DIV; i < 110; i++)
      if (q[i] !== 1'b1) tail++;
    check({tag, " bit-cell glitches"}, 32'(bad), 32'd0);
    check({tag, " idle after frame"}, 32'(tail), 32'd0);
    check({tag, " write_ready low cycles"}, 32'(lo), 32'(10*DIV));
  endtask

  initial begin
    logic [7:0] d;
    rst          = 1'b1;
    uart_rxd     = 1'b1;
    int_ack      = 1'b0;
    tx_data      = 8'd0;
    write_enable = 1'b0;
    m_data       = 8'd0;
    m_ready      = 1'b0;
    m_ovr        = 1'b0;
    ferr_cnt     = 0;
    rdy_hi       = 0;
    repeat (3) tick();
    check("rst uart_txd", 32'(uart_txd), 32'd1);
    check("rst write_ready", 32'(write_ready), 32'd1);
    check("rst rx_frame_err", 32'(rx_frame_err), 32'd0);
    check_rx("rst");
    rst = 1'b0;
    tick();

    send_tx(8'h41, "tx41");

    send_rx(8'h0D, 1'b1);
    check_rx("rx0D");
    ack();
    check_rx("rx0D ack");

    send_rx(8'h43, 1'b1);
    send_rx(8'h63, 1'b1);
    check_rx("overrun");
    ack();
    check_rx("overrun ack");

    ferr_cnt = 0;
    rdy_hi   = 0;
    uart_rxd = 1'b0;
    tick();
    tick();
    uart_rxd = 1'b1;
    idle(30);
    check("glitch frame_err", 32'(ferr_cnt), 32'd0);
    check("glitch read_ready", 32'(rdy_hi), 32'd0);

    ferr_cnt = 0;
    send_rx(8'h55, 1'b0);
    check("ferr pulses", 32'(ferr_cnt), 32'd1);
    check_rx("ferr");
    send_rx(8'h50, 1'b1);
    check_rx("after ferr");
    ack();

    for (int n = 0; n < 5; n++) begin
      d = 8'($urandom);
      send_rx(d, 1'b1);
      check_rx($sformatf("rand rx%0d", n));
      if ($urandom_range(0, 1) == 1) ack();
    end
    ack();

    for (int n = 0; n < 2; n++) begin
      d = 8'($urandom);
      send_tx(d, $sformatf("rand tx%0d", n));
    end

    d = 8'($urandom);
    tx_data      = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    repeat (35) tick();
    check("pre-rst data bit3", 32'(uart_txd), 32'(d[3]));
    #2;
    rst = 1'b1;
    #1;
    check("rst mid-tx uart_txd", 32'(uart_txd), 32'd1);
    check("rst mid-tx write_ready", 32'(write_ready), 32'd1);
    m_data  = 8'd0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    check_rx("rst mid-tx");
    tick();
    rst = 1'b0;
    tick();
    send_tx(8'h30, "tx30");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debug_uart.md
# debug_uart

Serial transceiver on the debug controller's COM side. It converts the board UART line into the byte-level handshake the debug controller consumes: read_ready, rx_data and int_ack for received command bytes, and write_ready, write_enable and tx_data for the hex digits it prints. Frames are 8N1, LSB first, at a fixed divisor of clk. The block sits between the FPGA UART pins and the debug controller.

## Interface
- CLK_DIV, 434: clk cycles per bit (50 MHz / 115200). Legal range 4..65535.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- uart_rxd  in  1  serial input, asynchronous to clk
- uart_txd  out  1  serial output, idle high
- rx_data  out  8  last received byte
- read_ready  out  1  rx_data valid, not yet acknowledged
- int_ack  in  1  consumer acknowledge; clears read_ready
- tx_data  in  8  byte to transmit
- write_enable  in  1  transmit request
- write_ready  out  1  transmitter idle, can accept a byte
- rx_overrun  out  1  sticky: a byte was dropped while read_ready was 1
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0

## Operation
- Reset values:
  - uart_txd=1, write_ready=1.
  - read_ready=0, rx_data=0.
  - rx_overrun=0, rx_frame_err=0.
  - Both FSMs reset to IDLE; all counters 0.
- RX input: uart_rxd passes through a 2-flop synchronizer. All RX decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synced rxd = 0. The bit counter is loaded with CLK_DIV/2 - 1 (integer division).
  - START, at the count's end:
    - rxd = 0 -> DATA, counter = CLK_DIV - 1.
    - rxd = 1 -> false start; return to IDLE, nothing reported.
  - DATA: sample once per CLK_DIV, 8 samples, shifted in LSB first. After the 8th sample -> STOP.
  - STOP, sample at mid-bit:
    - 1 -> byte complete.
    - 0 -> pulse rx_frame_err for one cycle, discard the byte, and go to IDLE only once rxd = 1. A break does not retrigger.
- Byte complete:
  - read_ready = 0: load rx_data and set read_ready.
  - read_ready = 1: drop the byte, keep rx_data unchanged, set rx_overrun.
- int_ack:
  - Clears read_ready and rx_overrun on the next edge.
  - If int_ack and byte complete occur in the same cycle, the new byte loads and read_ready stays 1 with no overrun.
- TX FSM states: IDLE, START, DATA, STOP.
  - Accept a byte when write_enable = 1 and write_ready = 1. Capture tx_data; write_ready goes 0 on the next edge.
  - write_enable held high beyond the accept cycle is ignored. The debug controller holds it for 2 cycles and this must produce exactly one frame.
  - Output sequence: START drives 0 for CLK_DIV cycles, then 8 DATA bits LSB first at CLK_DIV cycles each, then STOP drives 1 for CLK_DIV cycles, then IDLE.
  - write_ready returns to 1 in the first cycle after STOP completes.
- Counters: 16-bit down-counters per direction, bit index 3 bits. No wrap is reachable within the legal CLK_DIV range.
- Concurrency: RX and TX are fully independent and full-duplex.
- rst mid-frame: both FSMs abort immediately and all outputs take their reset values. A partially sent frame is truncated; uart_txd returns to 1.

## Timing
- TX, accept at edge N:
  - uart_txd = 0 from N+1.
  - Frame occupies 10*CLK_DIV cycles.
  - write_ready = 1 at N+1+10*CLK_DIV.
- RX: read_ready rises 2 (sync) + CLK_DIV/2 + 9*CLK_DIV cycles after the start edge on the pin, ±1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- DEBUG_UART_RX_MAJORITY_EN
  - Defined: each RX sample (start check, data bits, stop bit) is the 2-of-3 majority of synced rxd at mid-bit-1, mid-bit and mid-bit+1. Requires CLK_DIV >= 8.
  - Undefined: single sample at mid-bit.
  - The read_ready latency above changes by at most +1 cycle.

## Test plan
- CLK_DIV=8.
  - Stimulus: pulse write_enable for 2 cycles with tx_data=0x41.
  - Required: uart_txd shows 0,1,0,0,0,0,0,1,0,1 at 8 cycles per bit; exactly one frame; write_ready is low for 80 cycles.
- RX receive:
  - Stimulus: drive the 0x0D frame on uart_rxd.
  - Required: read_ready=1, rx_data=0x0D; after a 1-cycle int_ack, read_ready=0.
- Overrun:
  - Stimulus: send 0x43 then 0x63 without int_ack.
  - Required: rx_data=0x43, rx_overrun=1; int_ack clears both read_ready and rx_overrun.
- Glitch:
  - Stimulus: pull uart_rxd low for 2 cycles.
  - Required: no read_ready, no rx_frame_err; RX returns to IDLE.
- Framing error:
  - Stimulus: send a frame for 0x55 with stop bit 0.
  - Required: one-cycle rx_frame_err, read_ready stays 0; the next valid frame 0x50 is received correctly.
- Reset mid-TX:
  - Stimulus: assert rst in the 4th data bit.
  - Required: uart_txd=1 and write_ready=1 immediately; a new 0x30 frame then transmits cleanly.
